// File: rtl/bram_mem2mem_copy.sv
// Word-by-word copy from the RX BRAM (port B) into the TX BRAM (port B), driven by a
// GPIO control word; reads and writes overlap so one word moves per clock.
module bram_mem2mem_copy #(
   parameter int DEPTH_W = 11
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [31:0] conf_reg_O,
   output logic [31:0] conf_reg_I,
   output logic        BRAM1_RX_Clk,
   output logic        BRAM1_RX_Rst,
   output logic        BRAM1_RX_EN,
   output logic [3:0]  BRAM1_RX_WEN,
   output logic [31:0] BRAM1_RX_Addr,
   output logic [31:0] BRAM1_RX_Dout,
   input  logic [31:0] BRAM1_RX_Din,
   output logic        BRAM0_TX_Clk,
   output logic        BRAM0_TX_Rst,
   output logic        BRAM0_TX_EN,
   output logic [3:0]  BRAM0_TX_WEN,
   output logic [31:0] BRAM0_TX_Addr,
   output logic [31:0] BRAM0_TX_Dout,
   input  logic [31:0] BRAM0_TX_Din
);

   localparam int CW      = DEPTH_W + 1;
   localparam int MAX_LEN = 1 << DEPTH_W;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t             state, state_nxt;
   logic               start, clear, abort;
   logic [11:0]        len_in;
   logic               start_q, launch, len_ok, last_rd;
   logic               rd_en, wr_en, wr_valid;
   logic [DEPTH_W-1:0] rd_idx, wr_idx;
   logic [CW-1:0]      len_reg, wcnt;
   logic               done, err_len, aborted, busy;
   logic               unused_ok;

   assign start  = conf_reg_O[0];
   assign clear  = conf_reg_O[1];
   assign len_in = conf_reg_O[13:2];
   assign abort  = conf_reg_O[14];

   assign unused_ok = &{1'b0, BRAM0_TX_Din, conf_reg_O[31:15]};

   assign launch  = start & ~start_q;
   assign len_ok  = (len_in != 12'd0) && (int'(len_in) <= MAX_LEN);
   assign last_rd = ({1'b0, rd_idx} == (len_reg - CW'(1)));
   assign busy    = (state != IDLE);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Abort gates the strobes combinationally so the cycle in which it is seen moves no data.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      case (state)
         IDLE: begin
            if (launch && len_ok) state_nxt = RUN;
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               rd_en = 1'b1;
               wr_en = wr_valid;
               if (last_rd) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            state_nxt = IDLE;
            wr_en     = wr_valid & ~abort;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset leaves start_q high so a start bit already high at release is not an edge.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         start_q  <= 1'b1;
         rd_idx   <= '0;
         wr_idx   <= '0;
         wr_valid <= 1'b0;
         wcnt     <= '0;
         len_reg  <= '0;
         done     <= 1'b0;
         err_len  <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         start_q  <= start;
         wr_valid <= rd_en;
         wr_idx   <= rd_idx;
         if (rd_en) rd_idx <= rd_idx + DEPTH_W'(1);
         if (wr_en) wcnt <= wcnt + CW'(1);
         case (state)
            IDLE: begin
               if (launch) begin
                  if (len_ok) begin
                     len_reg <= CW'(len_in);
                     rd_idx  <= '0;
                     wcnt    <= '0;
                     done    <= 1'b0;
                     err_len <= 1'b0;
                     aborted <= 1'b0;
                  end else begin
                     err_len <= 1'b1;
                     done    <= 1'b1;
                  end
               end else if (clear) begin
                  done    <= 1'b0;
                  err_len <= 1'b0;
                  aborted <= 1'b0;
               end
            end
            RUN, FLUSH: begin
               if (abort) aborted <= 1'b1;
               else if (state == FLUSH) done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign conf_reg_I = {16'd0, 12'(wcnt), aborted, err_len, done, busy};

   assign BRAM1_RX_Clk  = sys_clk;
   assign BRAM1_RX_Rst  = sys_rst;
   assign BRAM1_RX_EN   = rd_en;
   assign BRAM1_RX_WEN  = 4'h0;
   assign BRAM1_RX_Addr = rd_en ? (32'(rd_idx) << 2) : 32'd0;
   assign BRAM1_RX_Dout = 32'd0;

   assign BRAM0_TX_Clk  = sys_clk;
   assign BRAM0_TX_Rst  = sys_rst;
   assign BRAM0_TX_EN   = wr_en;
   assign BRAM0_TX_WEN  = wr_en ? 4'hF : 4'h0;
   assign BRAM0_TX_Addr = wr_en ? (32'(wr_idx) << 2) : 32'd0;
   assign BRAM0_TX_Dout = wr_en ? BRAM1_RX_Din : 32'd0;

endmodule

// File: doc/bram_mem2mem_copy.md
BRAM_MEM2MEM_COPY -- requirements
Module: bram_mem2mem_copy

Interface
REQ-001 SHALL have parameter DEPTH_W, default 11, log2 of BRAM depth in 32-bit words (2048 words, 8 KB per BRAM).
REQ-002 SHALL have one clock and one reset: the clock is sys_clk, the reset is sys_rst, the reset is asynchronous and active-high.
REQ-003 SHALL have ports, each listed as name, direction, width, meaning:
- sys_clk  in  1  system clock; all state is on its rising edge.
- sys_rst  in  1  async active-high reset.
- conf_reg_O  in  32  control word from the CPU GPIO.
- conf_reg_I  out  32  status word to the CPU GPIO.
- BRAM1_RX_Clk, BRAM1_RX_Rst  out  1  RX port-B clock and reset; these are sys_clk and sys_rst passed through.
- BRAM1_RX_EN  out  1  RX port-B enable.
- BRAM1_RX_WEN  out  4  RX byte write enables; always 0.
- BRAM1_RX_Addr  out  32  RX byte address.
- BRAM1_RX_Dout  out  32  RX write data; always 0.
- BRAM1_RX_Din  in  32  RX read data, valid one cycle after EN.
- BRAM0_TX_Clk, BRAM0_TX_Rst  out  1  TX port-B clock and reset; these are sys_clk and sys_rst passed through.
- BRAM0_TX_EN  out  1  TX port-B enable.
- BRAM0_TX_WEN  out  4  TX byte write enables.
- BRAM0_TX_Addr  out  32  TX byte address.
- BRAM0_TX_Dout  out  32  TX write data.
- BRAM0_TX_Din  in  32  TX read data; unused.

Function
REQ-004 SHALL decode conf_reg_O as follows: [0] start, [1] clear, [13:2] LEN in words, [14] abort; all other bits are ignored.
REQ-005 SHALL encode conf_reg_I as follows: [0] busy, [1] done, [2] err_len, [3] aborted, [15:4] WCNT (words written), [31:16] 0.
REQ-006 SHALL detect start on a rising edge only: start_q is the registered start bit, and a launch condition is start=1 with start_q=0.
REQ-007 SHALL contain an FSM with states IDLE, RUN, FLUSH.
REQ-008 SHALL, on a launch in IDLE with 1 <= LEN <= 2^DEPTH_W, latch LEN, clear done, err_len, aborted and WCNT, zero the read index, and go to RUN.
REQ-009 SHALL, on a launch in IDLE with LEN = 0 or LEN > 2^DEPTH_W, stay in IDLE, set err_len=1 and done=1, and perform no BRAM access.
REQ-010 SHALL, in each RUN cycle, drive BRAM1_RX_EN=1 and BRAM1_RX_Addr = rd_idx*4, then increment rd_idx.
REQ-011 SHALL go from RUN to FLUSH in the cycle that issues read LEN-1.
REQ-012 SHALL write one cycle after each read: a valid bit and wr_idx are delayed one stage, and in that cycle the block drives BRAM0_TX_EN=1, BRAM0_TX_WEN=4'hF, BRAM0_TX_Addr = wr_idx*4 and BRAM0_TX_Dout = BRAM1_RX_Din (combinational pass-through), and increments WCNT.
REQ-013 SHALL, in FLUSH, perform the final write and return to IDLE at the next edge, setting done=1.
REQ-014 SHALL hold busy=1 for exactly LEN+1 cycles, starting at the edge after the launch; done rises on the same edge busy falls.
REQ-015 SHALL sustain throughput of one word per cycle with no gaps.
REQ-016 SHALL ignore start edges while busy=1.
REQ-017 SHALL, when abort=1 is sampled in RUN or FLUSH, go to IDLE at that edge, issue no further reads or writes, set aborted=1, leave done=0, and hold WCNT at the count of completed writes.
REQ-018 SHALL, when clear=1 is sampled in IDLE, zero done, err_len and aborted; clear has no effect while busy=1.
REQ-019 SHALL, when abort and start edges coincide in IDLE, perform the launch and ignore the abort.
REQ-020 SHALL, when clear and a launch coincide in IDLE, perform the launch.
REQ-021 SHALL use addresses only up to (2^DEPTH_W - 1)*4; with LEN = 2^DEPTH_W the last address is 0x1FFC and there is no wrap.
REQ-022 SHALL drive BRAM EN and WEN low in every cycle not covered by REQ-010 and REQ-012.

Reset
REQ-023 SHALL, while sys_rst=1, asynchronously force: FSM=IDLE; rd_idx, wr_idx, WCNT and the valid pipe to 0; all status bits and all BRAM EN, WEN, Addr and Dout outputs to 0.
REQ-024 SHALL reset start_q to 1, so a start bit held high through reset release does not launch a transfer.
REQ-025 SHALL, when reset is asserted mid-transfer, abandon the transfer without completing the pending write; after release the block is idle with done=0.

Verification
REQ-026 SHALL pass the following directed scenarios.
- Basic copy: preload RX[i]=0xA5000000+i; start, LEN=16 -> TX[0..15] equals RX[0..15], busy=1 for 17 cycles, status=0x0102 (WCNT=16, done).
- Full depth: LEN=2048 -> 2048 writes, last TX address 0x1FFC, WCNT=0x800, no write outside the range.
- Length errors: LEN=0, then LEN=2049 -> err_len=1 and done=1 each time, zero BRAM EN pulses; clear=1 -> status=0.
- Abort: LEN=100, abort asserted 10 cycles after busy rises -> aborted=1, done=0, WCNT=9; TX[9..99] untouched.
- Start re-edge while busy and start held across reset: busy re-launch ignored; start=1 during reset release -> no launch until start toggles 0 -> 1.
- Async reset at cycle 5 of LEN=32 -> all outputs 0 before the next clock edge; conf_reg_I=0 after release.
